// File: rtl/character_mover_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pacman_pkg
//  Brief    : Shared codes and constants for the character motion sequencer:
//             direction codes, character type codes, FSM state encoding and
//             default playfield limits.
//  Revision : 1.0  initial release
// ============================================================================
package pacman_pkg;

    // Direction codes as packed into dir_in, two bits per character
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Register-file character select codes, in sequencing order
    localparam logic [2:0] CHAR_PACMAN = 3'd0;
    localparam logic [2:0] CHAR_GHOST1 = 3'd1;
    localparam logic [2:0] CHAR_GHOST2 = 3'd2;
    localparam logic [2:0] CHAR_GHOST3 = 3'd3;
    localparam logic [2:0] CHAR_GHOST4 = 3'd4;

    // Default playfield limits (largest legal pixel on each axis)
    localparam int DEF_X_MAX = 159;
    localparam int DEF_Y_MAX = 119;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RDW   = 3'd2,
        ST_PROBE = 3'd3,
        ST_CHK   = 3'd4,
        ST_WR    = 3'd5,
        ST_NXT   = 3'd6,
        ST_DONE  = 3'd7
    } mover_state_t;

endpackage
`default_nettype wire

// File: rtl/character_mover_if.sv
`default_nettype none
// ============================================================================
//  Module   : character_mover_if
//  Brief    : Bundle of the sequencer's control, register-file and wall-map
//             signals. The master modport is the mover's view; the slave
//             modport is the environment (register file, wall map, frame
//             controller).
//  Revision : 1.0  initial release
// ============================================================================
interface character_mover_if #(
    parameter int NUM_CHARS = 5
);
    logic                   start;
    logic [2*NUM_CHARS-1:0] dir_in;
    logic [NUM_CHARS-1:0]   move_en;
    logic [7:0]             x_out;
    logic [7:0]             y_out;
    logic [7:0]             x_in;
    logic [7:0]             y_in;
    logic [2:0]             character_type;
    logic                   readwrite;
    logic [7:0]             map_x;
    logic [7:0]             map_y;
    logic                   map_req;
    logic                   map_is_wall;
    logic                   busy;
    logic                   done;
    logic [NUM_CHARS-1:0]   blocked;
    logic                   ghost_hit;

    modport master (
        input  start, dir_in, move_en, x_out, y_out, map_is_wall,
        output x_in, y_in, character_type, readwrite, map_x, map_y, map_req,
               busy, done, blocked, ghost_hit
    );

    modport slave (
        output start, dir_in, move_en, x_out, y_out, map_is_wall,
        input  x_in, y_in, character_type, readwrite, map_x, map_y, map_req,
               busy, done, blocked, ghost_hit
    );
endinterface
`default_nettype wire

// File: rtl/character_mover_next_pos_calc.sv
`default_nettype none
// ============================================================================
//  Module   : next_pos_calc
//  Brief    : Combinational one-step move with wrap-around at the playfield
//             edges. Only the axis selected by dir changes; 9-bit
//             intermediates keep out-of-range stored coordinates exact.
//  Revision : 1.0  initial release
// ============================================================================
module next_pos_calc
    import pacman_pkg::*;
#(
    parameter int STEP  = 1,
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MAX = DEF_Y_MAX
) (
    input  wire logic [7:0] cur_x,
    input  wire logic [7:0] cur_y,
    input  wire logic [1:0] dir,
    output logic      [7:0] cand_x,
    output logic      [7:0] cand_y
);

    localparam logic [8:0] c_STEP   = 9'(STEP);
    localparam logic [8:0] c_X_MAX  = 9'(X_MAX);
    localparam logic [8:0] c_Y_MAX  = 9'(Y_MAX);
    localparam logic [8:0] c_X_SPAN = 9'(X_MAX + 1);
    localparam logic [8:0] c_Y_SPAN = 9'(Y_MAX + 1);

    logic [8:0] w_x9;
    logic [8:0] w_y9;
    logic [8:0] w_nx;
    logic [8:0] w_ny;

    // Step the selected axis, wrapping to the opposite edge when it leaves the field
    always_comb begin
        w_x9 = {1'b0, cur_x};
        w_y9 = {1'b0, cur_y};
        w_nx = w_x9;
        w_ny = w_y9;
        case (dir)
            DIR_UP:    w_ny = (w_y9 < c_STEP) ? (w_y9 + c_Y_SPAN - c_STEP) : (w_y9 - c_STEP);
            DIR_DOWN:  w_ny = ((w_y9 + c_STEP) > c_Y_MAX) ? (w_y9 + c_STEP - c_Y_SPAN) : (w_y9 + c_STEP);
            DIR_LEFT:  w_nx = (w_x9 < c_STEP) ? (w_x9 + c_X_SPAN - c_STEP) : (w_x9 - c_STEP);
            default:   w_nx = ((w_x9 + c_STEP) > c_X_MAX) ? (w_x9 + c_STEP - c_X_SPAN) : (w_x9 + c_STEP);
        endcase
    end

    assign cand_x = w_nx[7:0];
    assign cand_y = w_ny[7:0];

endmodule
`default_nettype wire

// File: rtl/character_mover.sv
`default_nettype none
// ============================================================================
//  Module   : character_mover
//  Brief    : Per-frame motion sequencer. On each start tick it reads every
//             character's coordinates from the register file, computes a
//             one-step move, probes the wall map and writes back legal moves.
//             Optional build macro COLLISION_DETECT_EN enables the ghost/Pacman
//             overlap flag on ghost_hit; otherwise ghost_hit is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module character_mover
    import pacman_pkg::*;
#(
    parameter int NUM_CHARS = 5,
    parameter int STEP      = 1,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_MAX     = DEF_Y_MAX
) (
    input  wire logic         clock_50,
    input  wire logic         reset,
    character_mover_if.master bus
);

    localparam logic [2:0] c_LAST = 3'(NUM_CHARS - 1);

    mover_state_t         r_state;
    mover_state_t         w_next;
    logic [2:0]           r_idx;
    logic [7:0]           r_cur_x;
    logic [7:0]           r_cur_y;
    logic [1:0]           r_dir;
    logic                 r_men;
    logic                 r_busy;
    logic [NUM_CHARS-1:0] r_blk_frame;
    logic [NUM_CHARS-1:0] r_blocked;
    logic [7:0]           w_cand_x;
    logic [7:0]           w_cand_y;

    next_pos_calc #(
        .STEP  (STEP),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_next_pos (
        .cur_x  (r_cur_x),
        .cur_y  (r_cur_y),
        .dir    (r_dir),
        .cand_x (w_cand_x),
        .cand_y (w_cand_y)
    );

    // State register; reset aborts any frame in flight
    always_ff @(posedge clock_50) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_RD;
            ST_RD:    w_next = ST_RDW;
            ST_RDW:   w_next = ST_PROBE;
            ST_PROBE: w_next = ST_CHK;
            ST_CHK:   w_next = (!r_men || bus.map_is_wall) ? ST_NXT : ST_WR;
            ST_WR:    w_next = ST_NXT;
            ST_NXT:   w_next = (r_idx == c_LAST) ? ST_DONE : ST_RD;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Sequencer datapath: index, latched coordinates/direction, busy and blocked flags
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_idx       <= 3'd0;
            r_cur_x     <= 8'd0;
            r_cur_y     <= 8'd0;
            r_dir       <= DIR_UP;
            r_men       <= 1'b0;
            r_busy      <= 1'b0;
            r_blk_frame <= '0;
            r_blocked   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_idx       <= 3'd0;
                        r_busy      <= 1'b1;
                        r_blk_frame <= '0;
                    end
                end
                ST_RDW: begin
                    r_cur_x <= bus.x_out;
                    r_cur_y <= bus.y_out;
                    r_dir   <= bus.dir_in[{r_idx, 1'b0} +: 2];
                    r_men   <= bus.move_en[r_idx];
                end
                ST_CHK: begin
                    if (r_men && bus.map_is_wall) r_blk_frame[r_idx] <= 1'b1;
                end
                ST_NXT: begin
                    if (r_idx != c_LAST) r_idx <= r_idx + 3'd1;
                end
                ST_DONE: begin
                    r_blocked <= r_blk_frame;
                    r_busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Bus drive per state; idle default is a harmless Pacman read
    always_comb begin
        bus.character_type = CHAR_PACMAN;
        bus.readwrite      = 1'b0;
        bus.x_in           = 8'd0;
        bus.y_in           = 8'd0;
        bus.map_x          = 8'd0;
        bus.map_y          = 8'd0;
        bus.map_req        = 1'b0;
        bus.done           = 1'b0;
        case (r_state)
            ST_RD: begin
                bus.character_type = r_idx;
            end
            ST_PROBE: begin
                bus.map_x   = w_cand_x;
                bus.map_y   = w_cand_y;
                bus.map_req = 1'b1;
            end
            ST_WR: begin
                bus.readwrite      = 1'b1;
                bus.character_type = r_idx;
                bus.x_in           = w_cand_x;
                bus.y_in           = w_cand_y;
            end
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy    = r_busy;
    assign bus.blocked = r_blocked;

`ifdef COLLISION_DETECT_EN
    logic [7:0] r_pac_x;
    logic [7:0] r_pac_y;
    logic       r_hit;
    logic       w_moves;
    logic [7:0] w_fin_x;
    logic [7:0] w_fin_y;

    // Final position of the character being checked: the candidate if it will be written
    assign w_moves = r_men && !bus.map_is_wall;
    assign w_fin_x = w_moves ? w_cand_x : r_cur_x;
    assign w_fin_y = w_moves ? w_cand_y : r_cur_y;

    // Capture Pacman's final spot, then flag any ghost ending on it; flag clears per frame
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_pac_x <= 8'd0;
            r_pac_y <= 8'd0;
            r_hit   <= 1'b0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_hit <= 1'b0;
        end else if (r_state == ST_CHK) begin
            if (r_idx == CHAR_PACMAN) begin
                r_pac_x <= w_fin_x;
                r_pac_y <= w_fin_y;
            end else if (w_fin_x == r_pac_x && w_fin_y == r_pac_y) begin
                r_hit <= 1'b1;
            end
        end
    end

    assign bus.ghost_hit = (r_state == ST_DONE) && r_hit;
`else
    assign bus.ghost_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_character_mover.sv
`default_nettype none
// ============================================================================
//  Module   : tb_character_mover
//  Brief    : Directed bench for character_mover with a behavioural register
//             file (registered read) and a single-cell wall map (1-cycle
//             registered answer).
//  Revision : 1.0  initial release
// ============================================================================
module tb_character_mover;

`ifdef COLLISION_DETECT_EN
    localparam logic c_EXP_HIT = 1'b1;
`else
    localparam logic c_EXP_HIT = 1'b0;
`endif

    logic clk;
    logic reset;

    character_mover_if #(.NUM_CHARS(5)) bus ();

    character_mover #(
        .NUM_CHARS (5),
        .STEP      (1),
        .X_MAX     (159),
        .Y_MAX     (119)
    ) dut (
        .clock_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model with a bench-side load port
    logic [7:0] mem_x [8];
    logic [7:0] mem_y [8];
    logic       ld_en;
    logic [2:0] ld_idx;
    logic [7:0] ld_x;
    logic [7:0] ld_y;

    always @(posedge clk) begin
        if (ld_en) begin
            mem_x[ld_idx] <= ld_x;
            mem_y[ld_idx] <= ld_y;
        end else if (bus.readwrite) begin
            mem_x[bus.character_type] <= bus.x_in;
            mem_y[bus.character_type] <= bus.y_in;
        end
        bus.x_out <= mem_x[bus.character_type];
        bus.y_out <= mem_y[bus.character_type];
    end

    // Wall map: one configurable wall pixel
    logic       wall_en;
    logic [7:0] wall_x;
    logic [7:0] wall_y;

    always @(posedge clk) begin
        bus.map_is_wall <= bus.map_req && wall_en && (bus.map_x == wall_x) && (bus.map_y == wall_y);
    end

    int   n_checks;
    int   n_errors;
    int   cyc;
    int   wr;
    logic hit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pos(input int idx, input int x, input int y);
        @(negedge clk);
        ld_en  = 1'b1;
        ld_idx = 3'(idx);
        ld_x   = 8'(x);
        ld_y   = 8'(y);
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic load_defaults();
        set_pos(0, 10, 10);
        set_pos(1, 40, 35);
        set_pos(2, 45, 35);
        set_pos(3, 50, 35);
        set_pos(4, 55, 35);
    endtask

    task automatic check_pos(input string tag, input int idx, input int ex, input int ey);
        check({tag, ".x"}, 32'(mem_x[idx]), 32'(ex));
        check({tag, ".y"}, 32'(mem_y[idx]), 32'(ey));
    endtask

    // Issue one start, count cycles to done and write cycles; optionally re-pulse start mid-frame
    task automatic run_frame(input int mid_start, output int cycles, output int writes, output logic ghit);
        cycles = 0;
        writes = 0;
        ghit   = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        while (bus.done !== 1'b1 && cycles < 100) begin
            if (bus.readwrite === 1'b1) writes++;
            bus.start = (cycles == mid_start);
            @(posedge clk);
            #1 cycles++;
        end
        bus.start = 1'b0;
        ghit = bus.ghost_hit;
        check("busy_at_done", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.dir_in  = 10'b11_11_11_11_11;
        bus.move_en = 5'b11111;
        ld_en       = 1'b0;
        ld_idx      = 3'd0;
        ld_x        = 8'd0;
        ld_y        = 8'd0;
        wall_en     = 1'b0;
        wall_x      = 8'd0;
        wall_y      = 8'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      32'(bus.busy),           32'd0);
        check("rst_done",      32'(bus.done),           32'd0);
        check("rst_blocked",   32'(bus.blocked),        32'd0);
        check("rst_readwrite", 32'(bus.readwrite),      32'd0);
        check("rst_chartype",  32'(bus.character_type), 32'd0);
        check("rst_map_req",   32'(bus.map_req),        32'd0);
        check("rst_ghost_hit", 32'(bus.ghost_hit),      32'd0);
        check("rst_x_in",      32'(bus.x_in),           32'd0);

        // start coinciding with reset is dropped
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("start_with_reset_busy", 32'(bus.busy), 32'd0);

        // Full frame, everyone moves right, start re-pulsed mid-frame must be ignored
        load_defaults();
        run_frame(10, cyc, wr, hit);
        check("frame_cycles", 32'(cyc), 32'd30);
        check("frame_writes", 32'(wr), 32'd5);
        check("frame_blocked", 32'(bus.blocked), 32'd0);
        check_pos("frame_pac", 0, 11, 10);
        check_pos("frame_g1", 1, 41, 35);
        check_pos("frame_g2", 2, 46, 35);
        check_pos("frame_g3", 3, 51, 35);
        check_pos("frame_g4", 4, 56, 35);

        // Wrap-around cases on Pacman
        set_pos(0, 0, 10);
        bus.dir_in = 10'b11_11_11_11_10;
        run_frame(-1, cyc, wr, hit);
        check_pos("wrap_left", 0, 159, 10);

        set_pos(0, 10, 119);
        bus.dir_in = 10'b11_11_11_11_01;
        run_frame(-1, cyc, wr, hit);
        check_pos("wrap_down", 0, 10, 0);

        set_pos(0, 159, 5);
        bus.dir_in = 10'b11_11_11_11_11;
        run_frame(-1, cyc, wr, hit);
        check_pos("wrap_right", 0, 0, 5);

        set_pos(0, 10, 0);
        bus.dir_in = 10'b11_11_11_11_00;
        run_frame(-1, cyc, wr, hit);
        check_pos("wrap_up", 0, 10, 119);

        set_pos(0, 200, 10);
        bus.dir_in = 10'b11_11_11_11_11;
        run_frame(-1, cyc, wr, hit);
        check_pos("out_of_range_right", 0, 41, 10);

        // Wall in front of Pacman
        load_defaults();
        wall_en = 1'b1;
        wall_x  = 8'd11;
        wall_y  = 8'd10;
        run_frame(-1, cyc, wr, hit);
        check("wall_cycles", 32'(cyc), 32'd29);
        check("wall_writes", 32'(wr), 32'd4);
        check("wall_blocked", 32'(bus.blocked), 32'd1);
        check_pos("wall_pac", 0, 10, 10);
        check_pos("wall_g1", 1, 41, 35);
        wall_en = 1'b0;

        // Nobody moves
        load_defaults();
        bus.move_en = 5'b00000;
        run_frame(-1, cyc, wr, hit);
        check("nomove_cycles", 32'(cyc), 32'd25);
        check("nomove_writes", 32'(wr), 32'd0);
        check("nomove_blocked", 32'(bus.blocked), 32'd0);
        check_pos("nomove_pac", 0, 10, 10);
        check_pos("nomove_g4", 4, 55, 35);
        bus.move_en = 5'b11111;

        // Reset in idx 1 PROBE aborts the frame; only Pacman was written
        load_defaults();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_readwrite", 32'(bus.readwrite), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_pos("abort_pac", 0, 11, 10);
        check_pos("abort_g1", 1, 40, 35);
        run_frame(-1, cyc, wr, hit);
        check("after_abort_cycles", 32'(cyc), 32'd30);
        check_pos("after_abort_pac", 0, 12, 10);
        check_pos("after_abort_g1", 1, 41, 35);

        // Collision: Pacman and Ghost1 both move up, no overlap
        load_defaults();
        set_pos(0, 40, 34);
        set_pos(1, 40, 35);
        bus.dir_in = 10'b11_11_11_00_00;
        run_frame(-1, cyc, wr, hit);
        check_pos("coll_a_pac", 0, 40, 33);
        check_pos("coll_a_g1", 1, 40, 34);
        check("coll_a_hit", 32'(hit), 32'd0);

        // Collision: Pacman steps down onto a stationary Ghost1
        load_defaults();
        set_pos(0, 40, 34);
        set_pos(1, 40, 35);
        bus.dir_in  = 10'b11_11_11_00_01;
        bus.move_en = 5'b11101;
        run_frame(-1, cyc, wr, hit);
        check_pos("coll_b_pac", 0, 40, 35);
        check_pos("coll_b_g1", 1, 40, 35);
        check("coll_b_hit", 32'(hit), 32'(c_EXP_HIT));
        check("coll_b_hit_after", 32'(bus.ghost_hit), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
